word_break: RTL and testbench

WORD_BREAK -- requirements
Module: word_break

---
 rtl/word_break_if.sv | 27 ++
 rtl/word_break.sv | 98 +++++++++
 tb/tb_word_break.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_break_if.sv
// Handshake bundle for word_break: character stream in, assembled word out.
// The master drives characters and out_ready; the slave is the word assembler.
interface word_break_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORD   = 16
);
    localparam int LEN_W = $clog2(MAX_WORD + 1);

    logic [DATA_WIDTH-1:0]          in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [MAX_WORD*DATA_WIDTH-1:0] out_word;
    logic [LEN_W-1:0]               out_len;
    logic                           out_trunc;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_word, out_len, out_trunc, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_word, out_len, out_trunc, out_valid
    );
endinterface

// File: rtl/word_break.sv
// Splits a character stream into words on space/LF/CR and presents each
// word as a parallel buffer with its length and a truncation flag.
module word_break #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORD   = 16
) (
    input logic         clk,
    input logic         rstn,
    word_break_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_WORD + 1);
    localparam int BUF_W = MAX_WORD * DATA_WIDTH;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WORD);

    typedef enum logic {
        COLLECT,
        EMIT
    } state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             trunc_q, trunc_d;

    logic [7:0] low8;
    logic       is_delim;
    logic       in_fire;

    // Delimiter test works on an 8-bit view of the character.
    generate
        if (DATA_WIDTH >= 8) begin : g_wide
            assign low8 = bus.in_data[7:0];
        end else begin : g_narrow
            assign low8 = {{(8 - DATA_WIDTH){1'b0}}, bus.in_data};
        end
    endgenerate

    assign is_delim = (low8 == 8'h20) || (low8 == 8'h0A) || (low8 == 8'h0D);

    assign bus.in_ready  = (state_q == COLLECT) && rstn;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_word  = buf_q;
    assign bus.out_len   = len_q;
    assign bus.out_trunc = trunc_q;

    assign in_fire = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        trunc_d = trunc_q;

        case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    if (is_delim) begin
                        if (len_q != '0) begin
                            state_d = EMIT;
                        end
                    end else if (len_q < LEN_MAX) begin
                        for (int unsigned i = 0; i < MAX_WORD; i++) begin
                            if (len_q == LEN_W'(i)) begin
                                buf_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
                            end
                        end
                        len_d = len_q + 1'b1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    state_d = COLLECT;
                    buf_d   = '0;
                    len_d   = '0;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= COLLECT;
            buf_q   <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end
endmodule

// File: tb/tb_word_break.sv
// Directed bench for word_break: one task per scenario, inline checks.
module tb_word_break;
    localparam int DW    = 8;
    localparam int MW    = 16;
    localparam int LEN_W = $clog2(MW + 1);

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    logic [MW*DW-1:0] q_word [$];
    logic [LEN_W-1:0] q_len  [$];
    logic             q_trunc[$];

    word_break_if #(.DATA_WIDTH(DW), .MAX_WORD(MW)) bus ();

    word_break #(.DATA_WIDTH(DW), .MAX_WORD(MW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every output transfer; sampled on the falling edge ahead of it.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            q_word.push_back(bus.out_word);
            q_len.push_back(bus.out_len);
            q_trunc.push_back(bus.out_trunc);
        end
    end

    task automatic clear_q();
        q_word.delete();
        q_len.delete();
        q_trunc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int unsigned n;
        bit          done;
        n    = 0;
        done = 1'b0;
        bus.in_data  = c;
        bus.in_valid = 1'b1;
        while (!done && n < 64) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: char %h, in_ready stayed 0", c);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1 rstn = 1'b0;
        #2;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        total++;
        if (bus.out_word !== '0 || bus.out_len !== '0 || bus.out_trunc !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: word=%h len=%0d trunc=%b want all 0",
                            bus.out_word, bus.out_len, bus.out_trunc);
        end
        #9 rstn = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hi();
        clear_q();
        bus.out_ready = 1'b1;
        send_char(8'h68);
        send_char(8'h69);
        send_char(8'h20);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL hi_latency: out_valid=%b want 1", bus.out_valid);
        end
        total++;
        if (bus.out_word !== 128'h6968 || bus.out_len !== 5'd2 || bus.out_trunc !== 1'b0) begin
            bad++; $display("FAIL hi_word: word=%h len=%0d trunc=%b want 6968/2/0",
                            bus.out_word, bus.out_len, bus.out_trunc);
        end
        idle(1);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL hi_return: out_valid=%b in_ready=%b want 0/1",
                            bus.out_valid, bus.in_ready);
        end
        total++;
        if (bus.out_word !== '0 || bus.out_len !== '0) begin
            bad++; $display("FAIL hi_cleared: word=%h len=%0d want 0/0", bus.out_word, bus.out_len);
        end
        idle(2);
        total++;
        if (q_word.size() != 1) begin
            bad++; $display("FAIL hi_count: got %0d words want 1", q_word.size());
        end
    endtask

    task automatic test_delims();
        logic [7:0] s [0:7];
        s = '{8'h20, 8'h20, 8'h61, 8'h0A, 8'h0D, 8'h20, 8'h62, 8'h20};
        clear_q();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_char(s[i]);
        idle(3);
        total++;
        if (q_word.size() != 2) begin
            bad++; $display("FAIL delim_count: got %0d words want 2", q_word.size());
        end else begin
            total++;
            if (q_word[0] !== 128'h61 || q_len[0] !== 5'd1) begin
                bad++; $display("FAIL delim_word0: word=%h len=%0d want 61/1", q_word[0], q_len[0]);
            end
            total++;
            if (q_word[1] !== 128'h62 || q_len[1] !== 5'd1) begin
                bad++; $display("FAIL delim_word1: word=%h len=%0d want 62/1", q_word[1], q_len[1]);
            end
        end
    endtask

    task automatic test_trunc();
        logic [MW*DW-1:0] exp_w;
        int               not_ready;
        exp_w     = '0;
        not_ready = 0;
        for (int i = 0; i < 16; i++) exp_w[i*8 +: 8] = 8'h41 + 8'(i);
        clear_q();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready !== 1'b1) not_ready++;
            send_char(8'h41 + 8'(i));
        end
        total++;
        if (not_ready != 0) begin
            bad++; $display("FAIL trunc_ready: in_ready low on %0d chars want 0", not_ready);
        end
        send_char(8'h20);
        total++;
        if (bus.out_word !== exp_w || bus.out_len !== 5'd16 || bus.out_trunc !== 1'b1) begin
            bad++; $display("FAIL trunc_word: word=%h len=%0d trunc=%b want %h/16/1",
                            bus.out_word, bus.out_len, bus.out_trunc, exp_w);
        end
        idle(2);
        total++;
        if (q_word.size() != 1) begin
            bad++; $display("FAIL trunc_count: got %0d words want 1", q_word.size());
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        bus.out_ready = 1'b0;
        send_char(8'h61);
        send_char(8'h62);
        send_char(8'h63);
        send_char(8'h20);
        bus.in_data  = 8'h7A;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_word !== 128'h636261 ||
                bus.out_len !== 5'd3 || bus.out_trunc !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: valid=%b ready=%b word=%h len=%0d want 1/0/636261/3",
                                i, bus.out_valid, bus.in_ready, bus.out_word, bus.out_len);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);
        send_char(8'h64);
        send_char(8'h20);
        idle(2);
        total++;
        if (q_word.size() != 2) begin
            bad++; $display("FAIL hold_count: got %0d words want 2", q_word.size());
        end else begin
            total++;
            if (q_word[0] !== 128'h636261 || q_len[0] !== 5'd3) begin
                bad++; $display("FAIL hold_word0: word=%h len=%0d want 636261/3", q_word[0], q_len[0]);
            end
            total++;
            if (q_word[1] !== 128'h64 || q_len[1] !== 5'd1) begin
                bad++; $display("FAIL hold_word1: word=%h len=%0d want 64/1", q_word[1], q_len[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        bus.out_ready = 1'b1;
        send_char(8'h61);
        send_char(8'h62);
        #2 rstn = 1'b0;
        #1;
        total++;
        if (bus.out_word !== '0 || bus.out_len !== '0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: word=%h len=%0d ready=%b want 0/0/0",
                            bus.out_word, bus.out_len, bus.in_ready);
        end
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        send_char(8'h63);
        send_char(8'h20);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 128'h63 || bus.out_len !== 5'd1) begin
            bad++; $display("FAIL midreset_word: valid=%b word=%h len=%0d want 1/63/1",
                            bus.out_valid, bus.out_word, bus.out_len);
        end
        idle(2);
        total++;
        if (q_word.size() != 1) begin
            bad++; $display("FAIL midreset_count: got %0d words want 1", q_word.size());
        end
        clear_q();
        bus.out_ready = 1'b0;
        send_char(8'h71);
        send_char(8'h20);
        #2 rstn = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_len !== '0) begin
            bad++; $display("FAIL emitreset: valid=%b len=%0d want 0/0", bus.out_valid, bus.out_len);
        end
        #1 rstn = 1'b1;
        bus.out_ready = 1'b1;
        idle(3);
        total++;
        if (q_word.size() != 0) begin
            bad++; $display("FAIL emitreset_count: got %0d words want 0", q_word.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [0:5];
        s = '{8'h78, 8'h20, 8'h79, 8'h20, 8'h7A, 8'h20};
        clear_q();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_char(s[i]);
            if (s[i] == 8'h20) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_word !== {120'h0, s[i-1]}) begin
                    bad++; $display("FAIL b2b_latency%0d: valid=%b word=%h want 1/%h",
                                    i, bus.out_valid, bus.out_word, s[i-1]);
                end
            end
        end
        idle(2);
        total++;
        if (q_word.size() != 3) begin
            bad++; $display("FAIL b2b_count: got %0d words want 3", q_word.size());
        end else begin
            total++;
            if (q_word[0] !== 128'h78 || q_word[1] !== 128'h79 || q_word[2] !== 128'h7A) begin
                bad++; $display("FAIL b2b_order: %h %h %h want 78 79 7a", q_word[0], q_word[1], q_word[2]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_hi();
        test_delims();
        test_trunc();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
